// File: rtl/mult_arbiter.sv
// Round-robin arbiter/sequencer sharing one iterative multiplier among NUM_REQ requesters.
// Latency: gnt + mul_start 1 cycle after req; rsp_valid 1 cycle after mul_done (or TIMEOUT+1 cycles after gnt).
// Backpressure: holds RESP with rsp_data/rsp_err stable until the winner's rsp_ready; req is ignored meanwhile.
//
// Ports:
//   clk, rst (async active-low)
//   req/req_a/req_b   : per-requester request and packed operands (slice i -> requester i)
//   gnt               : one-hot pulse when the winner's operands are captured
//   rsp_valid/rsp_ready/rsp_data/rsp_err : one-hot result handshake back to the winner
//   mul_start/mul_a/mul_b/mul_y/mul_done : multiplier controller/datapath interface
//   busy              : high whenever an operation is in flight
module mult_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int RES_W   = 2*DATA_W,
  parameter int TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [RES_W-1:0]          rsp_data,
  output logic                      rsp_err,
  output logic                      mul_start,
  output logic [DATA_W-1:0]         mul_a,
  output logic [DATA_W-1:0]         mul_b,
  input  logic [RES_W-1:0]          mul_y,
  input  logic                      mul_done,
  output logic                      busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_BUSY, ST_RESP} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   win_q, win_d;
  logic [DATA_W-1:0]  a_q, a_d;
  logic [DATA_W-1:0]  b_q, b_d;
  logic [RES_W-1:0]   data_q, data_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // Round-robin pick: scan offsets from the highest down so the last hit is
  // the one closest to ptr. rr_sum is one bit wider to hold ptr+offset < 2*NUM_REQ.
  logic [IDX_W-1:0]   pick;
  logic               any_req;
  logic [IDX_W:0]     rr_sum;

  always_comb begin
    pick    = ptr_q;
    any_req = 1'b0;
    rr_sum  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      rr_sum = {1'b0, ptr_q} + (IDX_W+1)'(k);
      if (rr_sum >= (IDX_W+1)'(NUM_REQ)) begin
        rr_sum = rr_sum - (IDX_W+1)'(NUM_REQ);
      end
      if (req[rr_sum[IDX_W-1:0]]) begin
        pick    = rr_sum[IDX_W-1:0];
        any_req = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    a_d     = a_q;
    b_d     = b_q;
    data_d  = data_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          win_d   = pick;
          a_d     = req_a[pick*DATA_W +: DATA_W];
          b_d     = req_b[pick*DATA_W +: DATA_W];
          state_d = ST_START;
        end
      end
      ST_START: begin
        cnt_d   = '0;
        state_d = ST_BUSY;
      end
      ST_BUSY: begin
        cnt_d = cnt_q + 1'b1;
        // A done arriving on the last counted cycle still counts as success.
        if (mul_done) begin
          data_d  = mul_y;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready[win_q]) begin
          ptr_d   = (win_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      a_q     <= a_d;
      b_q     <= b_d;
      data_q  <= data_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Moore outputs decoded from the registered state only.
  assign gnt       = (state_q == ST_START) ? (NUM_REQ'(1) << win_q) : '0;
  assign rsp_valid = (state_q == ST_RESP)  ? (NUM_REQ'(1) << win_q) : '0;
  assign mul_start = (state_q == ST_START);
  assign busy      = (state_q != ST_IDLE);
  assign mul_a     = a_q;
  assign mul_b     = b_q;
  assign rsp_data  = data_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: directed scenarios then randomized transactions.
// The multiplier is modelled by the bench; expected grants, products and
// timing come from a round-robin pointer model and plain arithmetic.
module tb_mult_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;
  localparam int RES_W   = 16;
  localparam int TIMEOUT = 8;

  logic                      clk;
  logic                      rst;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [NUM_REQ-1:0]        rsp_ready;
  logic [RES_W-1:0]          rsp_data;
  logic                      rsp_err;
  logic                      mul_start;
  logic [DATA_W-1:0]         mul_a;
  logic [DATA_W-1:0]         mul_b;
  logic [RES_W-1:0]          mul_y;
  logic                      mul_done;
  logic                      busy;

  mult_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .RES_W(RES_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .mul_start(mul_start),
    .mul_a(mul_a), .mul_b(mul_b), .mul_y(mul_y), .mul_done(mul_done),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int                ptr_m;
  logic [DATA_W-1:0] op_a [NUM_REQ];
  logic [DATA_W-1:0] op_b [NUM_REQ];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_a[i*DATA_W +: DATA_W] = op_a[i];
      req_b[i*DATA_W +: DATA_W] = op_b[i];
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"},       32'(gnt),       0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    chk({tag, "_rsp_err"},   32'(rsp_err),   0);
    chk({tag, "_mul_start"}, 32'(mul_start), 0);
    chk({tag, "_busy"},      32'(busy),      0);
    chk({tag, "_mul_a"},     32'(mul_a),     0);
    chk({tag, "_mul_b"},     32'(mul_b),     0);
    chk({tag, "_rsp_data"},  32'(rsp_data),  0);
  endtask

  // One complete transaction starting from an observed IDLE cycle with req set.
  // done_at: BUSY cycle index (0-based) at which mul_done pulses; >= TIMEOUT means never.
  task automatic txn(input int done_at, input int ready_wait, input bit disturb,
                     input bit keep_req, output int w);
    logic [RES_W-1:0] exp_y;
    logic [RES_W-1:0] exp_d;
    bit               timed_out;
    int               j;
    w = -1;
    for (int k = 0; k < NUM_REQ; k++) begin
      int i;
      i = (ptr_m + k) % NUM_REQ;
      if (w < 0 && req[i]) w = i;
    end
    if (w < 0) w = 0;
    exp_y = RES_W'(op_a[w]) * RES_W'(op_b[w]);
    step();
    chk("start_gnt",       32'(gnt),       32'(1 << w));
    chk("start_mul_start", 32'(mul_start), 1);
    chk("start_busy",      32'(busy),      1);
    chk("start_mul_a",     32'(mul_a),     32'(op_a[w]));
    chk("start_mul_b",     32'(mul_b),     32'(op_b[w]));
    chk("start_rsp_valid", 32'(rsp_valid), 0);
    if (!keep_req) req[w] = 1'b0;
    step();
    timed_out = 1'b0;
    j = 0;
    while (1) begin
      chk("busy_gnt",       32'(gnt),       0);
      chk("busy_mul_start", 32'(mul_start), 0);
      chk("busy_rsp_valid", 32'(rsp_valid), 0);
      chk("busy_busy",      32'(busy),      1);
      if (j == done_at) begin
        mul_done = 1'b1;
        mul_y    = exp_y;
      end else begin
        mul_y    = RES_W'($urandom);
      end
      step();
      mul_done = 1'b0;
      if (j == done_at) break;
      if (j == TIMEOUT - 1) begin
        timed_out = 1'b1;
        break;
      end
      j++;
    end
    exp_d = timed_out ? '0 : exp_y;
    for (int r = 0; r <= ready_wait; r++) begin
      chk("resp_rsp_valid", 32'(rsp_valid), 32'(1 << w));
      chk("resp_rsp_data",  32'(rsp_data),  32'(exp_d));
      chk("resp_rsp_err",   32'(rsp_err),   32'(timed_out));
      chk("resp_gnt",       32'(gnt),       0);
      chk("resp_mul_start", 32'(mul_start), 0);
      if (r == ready_wait) begin
        rsp_ready = NUM_REQ'(1 << w);
      end else if (disturb) begin
        rsp_ready = NUM_REQ'($urandom) & ~NUM_REQ'(1 << w);
        mul_done  = 1'($urandom);
        mul_y     = RES_W'($urandom);
        req       = req | NUM_REQ'($urandom);
      end else begin
        rsp_ready = '0;
      end
      step();
      mul_done = 1'b0;
    end
    rsp_ready = '0;
    chk("idle_busy",      32'(busy),      0);
    chk("idle_rsp_valid", 32'(rsp_valid), 0);
    chk("idle_gnt",       32'(gnt),       0);
    ptr_m = (w + 1) % NUM_REQ;
  endtask

  initial begin
    int w;
    rst = 1'b0; req = '0; rsp_ready = '0; mul_y = '0; mul_done = 1'b0;
    req_a = '0; req_b = '0; ptr_m = 0;
    for (int i = 0; i < NUM_REQ; i++) begin op_a[i] = '0; op_b[i] = '0; end

    // Reset state
    step(); step();
    chk_all_zero("reset");
    rst = 1'b1;

    // 1: single request 3*5
    op_a[0] = 8'd3; op_b[0] = 8'd5; set_ops();
    req = 4'b0001;
    txn(2, 0, 0, 0, w);

    // 2: all requesters held high from reset, ready immediate
    rst = 1'b0; step(); rst = 1'b1; ptr_m = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      op_a[i] = DATA_W'(10 + i); op_b[i] = DATA_W'(20 + 3*i);
    end
    set_ops();
    req = 4'b1111;
    for (int n = 0; n < 5; n++) txn(n % 3, 0, 0, 1, w);

    // 3: serve requester 2, then 0101 must go 0 before 2
    req = 4'b0100;
    txn(1, 0, 0, 0, w);
    req = 4'b0101;
    txn(0, 0, 0, 0, w);
    txn(3, 0, 0, 0, w);

    // 4: response stalled 10 cycles while done/req/foreign ready toggle
    op_a[1] = 8'hff; op_b[1] = 8'hff; set_ops();
    req = 4'b0010;
    txn(4, 10, 1, 0, w);

    // 5: timeout, then done on the final count
    req = 4'b0000; step();
    req = 4'b1000;
    txn(1000, 1, 0, 0, w);
    req = 4'b0001;
    txn(TIMEOUT - 1, 0, 0, 0, w);

    // 6: async reset mid-BUSY, then 1000 is served normally
    req = 4'b0010;
    step(); step(); step();
    req = 4'b0000;
    rst = 1'b0;
    #1;
    chk_all_zero("midreset");
    step();
    rst = 1'b1;
    ptr_m = 0;
    op_a[3] = 8'd7; op_b[3] = 8'd9; set_ops();
    req = 4'b1000;
    txn(0, 0, 0, 0, w);

    // Randomized transactions
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        req = '0;
        step();
        chk("rand_idle_busy", 32'(busy), 0);
        chk("rand_idle_gnt",  32'(gnt),  0);
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        op_a[i] = DATA_W'($urandom); op_b[i] = DATA_W'($urandom);
      end
      set_ops();
      req = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
      txn($urandom_range(0, TIMEOUT + 2), $urandom_range(0, 3),
          1'($urandom), 1'($urandom), w);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
